// File: rtl/oram_evict_writer_if.sv
// Request channel and bucket-RAM bus of the ORAM eviction writer.
// The engine takes the slave view; the requester/RAM side takes the master view.
interface oram_evict_writer_if #(
  parameter int D = 6,
  parameter int K = 3,
  parameter int A = 8
) ();
  localparam int TW = 2 + (D - 1) + D + 8 * A;

  logic            put_valid;
  logic            put_ready;
  logic            put_dummy;
  logic [TW-1:0]   put_tuple;
  logic [D-2:0]    flush_leaf;

  logic            mem_rd_en;
  logic            mem_wr_en;
  logic [D-1:0]    mem_addr;
  logic [K*TW-1:0] mem_wdata;
  logic [K*TW-1:0] mem_rdata;

  modport master (
    output put_valid, put_dummy, put_tuple, flush_leaf, mem_rdata,
    input  put_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  put_valid, put_dummy, put_tuple, flush_leaf, mem_rdata,
    output put_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/oram_evict_writer.sv
// ORAM write-side engine: put a fetched tuple back into the root bucket, then
// run one eviction pass down a caller-chosen leaf path.
module oram_evict_writer #(
  parameter int D = 6,
  parameter int K = 3,
  parameter int A = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  oram_evict_writer_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [7:0]         overflow_cnt
);
  localparam int TW      = 2 + (D - 1) + D + 8 * A;
  localparam int BW      = K * TW;
  localparam int LW      = $clog2(D);
  localparam int EN_BIT  = TW - 1;
  localparam int PV_BIT  = TW - 2;
  localparam int POS_LSB = TW - 1 - D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ROOT,
    S_CAP_ROOT,
    S_RD_LOW,
    S_CAP_LOW,
    S_WR_UP,
    S_WR_LEAF
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] tuple_reg;
  logic          dummy_reg;
  logic [D-2:0]  leaf_reg;
  logic [D-1:0]  node_reg;
  logic [LW-1:0] level_reg;
  logic [BW-1:0] up_reg;
  logic [BW-1:0] low_reg;
  logic [7:0]    overflow_cnt_reg;

  logic          leaf_bit;
  logic [D-1:0]  child_node;
  logic [K-1:0]  rd_free;
  logic [K-1:0]  up_elig;
  logic          root_full;

  // Heap numbering: the child on the flush path is 2*node + path bit.
  assign leaf_bit   = leaf_reg[level_reg];
  assign child_node = {node_reg[D-2:0], leaf_bit};

  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    logic [D-2:0] up_pos;
    assign up_pos      = up_reg[gi*TW + POS_LSB +: D-1];
    assign rd_free[gi] = ~bus.mem_rdata[gi*TW + EN_BIT];
    assign up_elig[gi] = up_reg[gi*TW + EN_BIT] & up_reg[gi*TW + PV_BIT] &
                         (up_pos[level_reg] == leaf_bit);
  end

  assign root_full = ~|rd_free;

  // Root insert: the incoming tuple takes the lowest-index free slot.
  logic [TW-1:0] ins_tuple;
  logic [BW-1:0] root_ins;
  logic          ins_hit;

  always_comb begin
    ins_tuple         = tuple_reg;
    ins_tuple[EN_BIT] = 1'b1;
    ins_tuple[PV_BIT] = 1'b1;
    root_ins          = bus.mem_rdata;
    ins_hit           = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (!ins_hit && rd_free[j]) begin
        root_ins[j*TW +: TW] = ins_tuple;
        ins_hit              = 1'b1;
      end
    end
  end

  // Merge UP into the freshly read LOW bucket; a tuple that finds no room stays put.
  logic [BW-1:0] up_merged;
  logic [BW-1:0] low_merged;
  logic [K-1:0]  low_avail;
  logic          placed;

  always_comb begin
    up_merged  = up_reg;
    low_merged = bus.mem_rdata;
    low_avail  = rd_free;
    placed     = 1'b0;
    for (int j = 0; j < K; j++) begin
      placed = 1'b0;
      for (int m = 0; m < K; m++) begin
        if (up_elig[j] && !placed && low_avail[m]) begin
          low_merged[m*TW +: TW] = up_reg[j*TW +: TW];
          low_avail[m]           = 1'b0;
          placed                 = 1'b1;
        end
      end
      if (placed) begin
        up_merged[j*TW + EN_BIT] = 1'b0;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    done          = 1'b0;
    overflow      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.put_valid) begin
          state_next = S_RD_ROOT;
        end
      end
      S_RD_ROOT: begin
        bus.mem_rd_en = 1'b1;
        state_next    = S_CAP_ROOT;
      end
      S_CAP_ROOT: begin
        overflow   = !dummy_reg && root_full;
        state_next = S_RD_LOW;
      end
      S_RD_LOW: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = child_node - D'(1);
        state_next    = S_CAP_LOW;
      end
      S_CAP_LOW: begin
        state_next = S_WR_UP;
      end
      S_WR_UP: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = node_reg - D'(1);
        bus.mem_wdata = up_reg;
        state_next    = (level_reg == LW'(D - 2)) ? S_WR_LEAF : S_RD_LOW;
      end
      S_WR_LEAF: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = node_reg - D'(1);
        bus.mem_wdata = up_reg;
        done          = 1'b1;
        state_next    = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      tuple_reg        <= '0;
      dummy_reg        <= 1'b0;
      leaf_reg         <= '0;
      node_reg         <= '0;
      level_reg        <= '0;
      up_reg           <= '0;
      low_reg          <= '0;
      overflow_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (bus.put_valid) begin
            tuple_reg <= bus.put_tuple;
            dummy_reg <= bus.put_dummy;
            leaf_reg  <= bus.flush_leaf;
            node_reg  <= D'(1);
            level_reg <= '0;
          end
        end
        S_CAP_ROOT: begin
          // A full root with a real request simply keeps its old contents.
          up_reg <= dummy_reg ? bus.mem_rdata : root_ins;
          if (overflow && (overflow_cnt_reg != 8'hFF)) begin
            overflow_cnt_reg <= overflow_cnt_reg + 8'd1;
          end
        end
        S_CAP_LOW: begin
          up_reg  <= up_merged;
          low_reg <= low_merged;
        end
        S_WR_UP: begin
          up_reg    <= low_reg;
          node_reg  <= child_node;
          level_reg <= level_reg + LW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.put_ready = (state_reg == S_IDLE);
  assign busy          = (state_reg != S_IDLE);
  assign overflow_cnt  = overflow_cnt_reg;

endmodule

// File: doc/oram_evict_writer.md
Name: oram_evict_writer

Overview:
- Write-side engine of the ORAM tree. It takes a block tuple returned by the fetch path and inserts it into a free slot of the root bucket (put_back).
- It then runs one eviction pass (flush) along a caller-supplied leaf path. Each tuple is pushed as far down toward its assigned leaf as free slots allow.
- It owns the single-port bucket RAM during an operation. The fetch/read engine is the other end of the same tree.

Parameters:
- D, 6: tree depth in levels; root is level 0, leaves are level D-1; 2^D-1 buckets; leaf label is D-1 bits; block number is D bits.
- K, 3: tuples per bucket.
- A, 8: bytes per block value.
- TW, 2+(D-1)+D+8*A: tuple width. Field order MSB to LSB: empty_n, pos_valid, pos[D-2:0], bnum[D-1:0], val[8A-1:0].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- put_valid  in  1  request valid
- put_ready  out  1  high only in IDLE
- put_dummy  in  1  1 = skip the insert, still flush (oblivious dummy access)
- put_tuple  in  TW  tuple to insert; forced to empty_n=1, pos_valid=1 on insert
- flush_leaf  in  D-1  eviction path label, sampled on accept
- mem_rd_en  out  1  bucket read strobe; data returns exactly 1 cycle later
- mem_wr_en  out  1  bucket write strobe
- mem_addr  out  D  bucket index = heap node number - 1
- mem_wdata  out  K*TW  slot j occupies bits [j*TW +: TW]
- mem_rdata  in  K*TW  read data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the final write
- overflow  out  1  one-cycle pulse when the root has no free slot
- overflow_cnt  out  8  saturating overflow count

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0 except put_ready=1; state IDLE; internal bucket registers cleared.
- Reset mid-operation: abort immediately with no further mem strobes. RAM keeps the last completed write. overflow_cnt clears.
- Handshake: accept on put_valid && put_ready. On accept, latch put_tuple, put_dummy and flush_leaf; input changes after accept are ignored.
- A slot is free iff empty_n==0.
- Path: node(0)=1; node(l+1) = 2*node(l) + flush_leaf[l], so path bits are consumed LSB first. mem_addr = node - 1.
- States, one RAM access per cycle, never rd and wr together:
  - IDLE -> RD_ROOT: rd addr 0.
  - RD_ROOT -> CAP_ROOT: capture rdata into UP. Unless dummy, write the tuple into the lowest-index free slot. If no slot is free: pulse overflow, increment overflow_cnt (saturate at 255), drop the tuple.
  - CAP_ROOT -> RD_LOW: read node(l+1).
  - RD_LOW -> CAP_LOW: capture into LOW, then merge.
  - CAP_LOW -> WR_UP: write UP to node(l); move LOW into UP; l++.
  - WR_UP -> RD_LOW while l < D-1.
  - WR_UP -> WR_LEAF when l == D-1.
  - WR_LEAF: write UP to the leaf node; pulse done -> IDLE.
- Merge rule:
  - Scan UP slots j = 0..K-1 ascending.
  - A tuple is eligible iff empty_n && pos_valid && pos[l] == flush_leaf[l].
  - Each eligible tuple moves to the lowest-index free LOW slot; the UP slot's empty_n clears.
  - If LOW has no free slot, the tuple stays in UP. No data is lost.
  - Ineligible and empty slots are untouched.
  - The full merge is combinational within the CAP_LOW cycle.
- Latency: accept at cycle 0 -> done at cycle 3D (18 for D=6); put_ready returns the next cycle. Throughput is one request per 3D+1 cycles.
- Exactly D reads and D writes per request, dummy or not, with an identical address sequence for dummy and real requests.
- put_valid while busy is ignored; the requester holds it.
- Tuples with pos_valid=0 never move.
- Equal-priority conflicts resolve by lowest slot index.

Test Plan:
- Empty tree, tuple bnum=5, pos=0b10110, flush_leaf=0b10110 -> the tuple ends in leaf node 1+0b01101 path (addr 44), slot 0. All upper path buckets end empty; done at cycle 18.
- Root holds 3 valid tuples, real put -> overflow pulse; overflow_cnt 0->1. Flush still performs 6 reads and 6 writes. Saturation at 255 is covered after 256 overflows.
- put_dummy=1 with root slots [valid pos=0b00001, empty, empty], flush_leaf=0b00001 -> no insert. The tuple reaches the leaf; the address sequence matches the real-put run.
- Divergence: tuple pos=0b00011, flush_leaf=0b00001 -> the tuple moves to level 1 (addr 2) and stops there, because pos[1]=1 while flush_leaf[1]=0.
- Full lower bucket: level-1 node pre-filled with 3 valid tuples; eligible root tuple -> it stays in root slot. The root writes back unchanged and no overflow pulses.
- Reset asserted at cycle 7 of an operation -> outputs go to reset values asynchronously with no further mem strobes. A new request is accepted one cycle after rst_n deasserts and completes normally.
